// File: rtl/dlatn_bank.sv
// dlatn_bank: CHANNELS x WIDTH synchronous gated-latch bank with a coherent
// snapshot/readback sequencer on a valid/ready port.
// Optional feature macro: DLATN_BANK_WIDTH_CHECK_EN (per-channel minimum
// gate-open width check driving the sticky ERR flags; ERR tied to 0 otherwise).
module dlatn_bank #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned MIN_OPEN = 2
) (
  input  logic                                           CLK,
  input  logic                                           RST,
  input  logic [CHANNELS*WIDTH-1:0]                      D,
  input  logic [CHANNELS-1:0]                            GN,
  input  logic                                           MODE,
  output logic [CHANNELS*WIDTH-1:0]                      Q,
  input  logic                                           RD_START,
  output logic                                           RD_VALID,
  input  logic                                           RD_READY,
  output logic [WIDTH-1:0]                               RD_DATA,
  output logic [$clog2((CHANNELS > 1) ? CHANNELS : 2)-1:0] RD_CH,
  output logic                                           RD_DONE,
  output logic [CHANNELS-1:0]                            ERR
);

  localparam int unsigned CW = $clog2((CHANNELS > 1) ? CHANNELS : 2);
  localparam logic [CW-1:0] LAST_IDX = CW'(CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SNAP   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t                           state;
  state_t                           state_nxt;
  logic [CHANNELS-1:0][WIDTH-1:0]   held;
  logic [CHANNELS-1:0][WIDTH-1:0]   shadow;
  logic [CW-1:0]                    idx;
  logic                             accept_last;

  // Reject degenerate configurations at elaboration.
  if (WIDTH == 0) begin : g_bad_width
    $error("dlatn_bank: WIDTH must be >= 1");
  end
  if (CHANNELS == 0) begin : g_bad_channels
    $error("dlatn_bank: CHANNELS must be >= 1");
  end
  if (MIN_OPEN == 0) begin : g_bad_min_open
    $error("dlatn_bank: MIN_OPEN must be >= 1");
  end

  // Hold register: capture D on every edge where the channel gate is open.
  always_ff @(posedge CLK) begin
    if (RST) begin
      held <= '0;
    end else begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        if (!GN[c]) held[c] <= D[c*WIDTH +: WIDTH];
      end
    end
  end

  // Channel output: transparent bypass when open in MODE=0, else held value.
  always_comb begin
    Q = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      Q[c*WIDTH +: WIDTH] = (!MODE && !GN[c] && !RST) ? D[c*WIDTH +: WIDTH] : held[c];
    end
  end

  // Sequencer state register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Sequencer next-state logic; RD_START is only honoured in IDLE.
  always_comb begin
    state_nxt   = state;
    accept_last = 1'b0;
    case (state)
      IDLE:   if (RD_START) state_nxt = SNAP;
      SNAP:   state_nxt = STREAM;
      STREAM: begin
        if (RD_READY && (idx == LAST_IDX)) begin
          accept_last = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot capture, beat index and end-of-stream pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow  <= '0;
      idx     <= '0;
      RD_DONE <= 1'b0;
    end else begin
      RD_DONE <= accept_last;
      if (state == SNAP) begin
        shadow <= held;
        idx    <= '0;
      end else if ((state == STREAM) && RD_READY) begin
        idx <= accept_last ? '0 : idx + CW'(1);
      end
    end
  end

  // Readback port decode; data and channel are zeroed outside a beat.
  always_comb begin
    RD_VALID = (state == STREAM);
    RD_DATA  = RD_VALID ? shadow[idx] : '0;
    RD_CH    = RD_VALID ? idx : '0;
  end

`ifdef DLATN_BANK_WIDTH_CHECK_EN
  localparam int unsigned OW = $clog2(MIN_OPEN + 1);
  localparam logic [OW-1:0] OPEN_SAT = OW'(MIN_OPEN);

  logic [CHANNELS-1:0][OW-1:0] open_cnt;

  // Count consecutive open cycles; flag a close that comes too early.
  always_ff @(posedge CLK) begin
    if (RST) begin
      open_cnt <= '0;
      ERR      <= '0;
    end else begin
      for (int c = 0; c < int'(CHANNELS); c++) begin
        if (!GN[c]) begin
          if (open_cnt[c] != OPEN_SAT) open_cnt[c] <= open_cnt[c] + OW'(1);
        end else begin
          if ((open_cnt[c] != '0) && (open_cnt[c] != OPEN_SAT)) ERR[c] <= 1'b1;
          open_cnt[c] <= '0;
        end
      end
    end
  end
`else
  assign ERR = '0;
`endif

endmodule

// File: tb/tb_dlatn_bank.sv
// Self-checking bench for dlatn_bank: directed steps plus random gate/data
// traffic checked against an array-based behavioural model.
module tb_dlatn_bank;

  localparam int W        = 8;
  localparam int C        = 4;
  localparam int MIN_OPEN = 2;

  logic          CLK;
  logic          RST;
  logic [C*W-1:0] D;
  logic [C-1:0]  GN;
  logic          MODE;
  logic [C*W-1:0] Q;
  logic          RD_START;
  logic          RD_VALID;
  logic          RD_READY;
  logic [W-1:0]  RD_DATA;
  logic [1:0]    RD_CH;
  logic          RD_DONE;
  logic [C-1:0]  ERR;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: held value per channel.
  logic [7:0] mh [C];
`ifdef DLATN_BANK_WIDTH_CHECK_EN
  logic       mer  [C];
  int         orun [C];
`endif

  dlatn_bank #(.WIDTH(W), .CHANNELS(C), .MIN_OPEN(MIN_OPEN)) dut (
    .CLK(CLK), .RST(RST), .D(D), .GN(GN), .MODE(MODE), .Q(Q),
    .RD_START(RD_START), .RD_VALID(RD_VALID), .RD_READY(RD_READY),
    .RD_DATA(RD_DATA), .RD_CH(RD_CH), .RD_DONE(RD_DONE), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] exp_q();
    logic [31:0] r;
    r = '0;
    for (int c = 0; c < C; c++)
      r[c*W +: W] = (!MODE && !GN[c] && !RST) ? D[c*W +: W] : mh[c];
    return r;
  endfunction

  function automatic logic [3:0] exp_err();
    logic [3:0] r;
    r = '0;
`ifdef DLATN_BANK_WIDTH_CHECK_EN
    for (int c = 0; c < C; c++) r[c] = mer[c];
`endif
    return r;
  endfunction

  // Apply the rules for one rising edge using the inputs as currently driven.
  task automatic model_step();
    for (int c = 0; c < C; c++) begin
      if (RST) begin
        mh[c] = 8'h00;
`ifdef DLATN_BANK_WIDTH_CHECK_EN
        mer[c]  = 1'b0;
        orun[c] = 0;
`endif
      end else if (!GN[c]) begin
        mh[c] = D[c*W +: W];
`ifdef DLATN_BANK_WIDTH_CHECK_EN
        orun[c] = orun[c] + 1;
`endif
      end else begin
`ifdef DLATN_BANK_WIDTH_CHECK_EN
        if (orun[c] > 0 && orun[c] < MIN_OPEN) mer[c] = 1'b1;
        orun[c] = 0;
`endif
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_q(input string tag);
    chk({tag, "_q"}, 64'(Q), 64'(exp_q()));
    chk({tag, "_err"}, 64'(ERR), 64'(exp_err()));
  endtask

  // One full readback; optional stall, D churn and ignored RD_START pokes.
  task automatic do_read(input int stall_beat, input int stall_cyc, input bit churn, input bit poke);
    logic [7:0] snap [C];
    int         nstall;
    bit         last_try;
    RD_READY = 1'b0;
    RD_START = 1'b1;
    tick();
    RD_START = 1'b0;
    for (int c = 0; c < C; c++) snap[c] = mh[c];
    #1;
    chk("snap_valid", 64'(RD_VALID), 64'(0));
    if (churn) begin
      GN = '0;
      D  = $urandom;
    end
    tick();
    for (int b = 0; b < C; b++) begin
      nstall = (b == stall_beat) ? stall_cyc : 0;
      for (int s = 0; s <= nstall; s++) begin
        last_try = (s == nstall);
        RD_READY = last_try;
        RD_START = (poke && last_try && (b == 1 || b == C - 1));
        if (churn) D = $urandom;
        #1;
        chk("beat_valid", 64'(RD_VALID), 64'(1));
        chk("beat_ch", 64'(RD_CH), 64'(b));
        chk("beat_data", 64'(RD_DATA), 64'(snap[b]));
        chk("beat_done", 64'(RD_DONE), 64'(0));
        chk_q("stream");
        tick();
      end
    end
    RD_READY = 1'b0;
    RD_START = 1'b0;
    GN = '1;
    #1;
    chk("done_pulse", 64'(RD_DONE), 64'(1));
    chk("idle_valid", 64'(RD_VALID), 64'(0));
    chk("idle_data", 64'(RD_DATA), 64'(0));
    chk("idle_ch", 64'(RD_CH), 64'(0));
    tick();
    chk("done_clear", 64'(RD_DONE), 64'(0));
    chk("no_restart", 64'(RD_VALID), 64'(0));
    tick();
    chk("no_restart2", 64'(RD_VALID), 64'(0));
  endtask

  initial begin
    // Reset dominates an open gate and a read request.
    RST = 1'b1; D = '1; GN = '0; MODE = 1'b0; RD_START = 1'b1; RD_READY = 1'b0;
    tick();
    tick();
    chk("rst_q", 64'(Q), 64'(0));
    chk("rst_valid", 64'(RD_VALID), 64'(0));
    chk("rst_done", 64'(RD_DONE), 64'(0));
    chk("rst_err", 64'(ERR), 64'(0));
    chk("rst_data", 64'(RD_DATA), 64'(0));
    RD_START = 1'b0; GN = '1; D = '0; MODE = 1'b1;
    tick();
    RST = 1'b0;

    // MODE=1: one-cycle latency on channel 0 only.
    GN = 4'b1110; D = 32'h0000_00A5;
    #1;
    chk("m1_before", 64'(Q), 64'(32'h0000_0000));
    tick();
    chk("m1_after", 64'(Q), 64'(32'h0000_00A5));
    GN = 4'b1111;

    // MODE=0: zero-cycle transparency, then hold on close.
    MODE = 1'b0; GN = 4'b1101; D = 32'h0000_1100;
    #1;
    chk("m0_follow1", 64'(Q), 64'(32'h0000_11A5));
    #2 D = 32'h0000_2200;
    #1;
    chk("m0_follow2", 64'(Q), 64'(32'h0000_22A5));
    tick();
    GN = 4'b1111; D = 32'h0000_3300;
    #1;
    chk("m0_hold", 64'(Q), 64'(32'h0000_22A5));
    chk_q("m0_model");
    tick();

    // Random gate/data traffic in both modes.
    for (int m = 0; m < 2; m++) begin
      MODE = m[0];
      for (int i = 0; i < 30; i++) begin
        D  = $urandom;
        GN = 4'($urandom);
        #1;
        chk_q("rand_a");
        #3 D = $urandom;
        #1;
        chk_q("rand_b");
        chk("rand_valid", 64'(RD_VALID), 64'(0));
        tick();
      end
    end
    GN = '1;
    tick();

    // Readback with a 3-cycle stall on beat 1.
    MODE = 1'b1; GN = '0; D = 32'h4433_2211;
    tick();
    GN = '1;
    #1;
    chk("held_load", 64'(Q), 64'(32'h4433_2211));
    do_read(1, 3, 1'b0, 1'b0);

    // Coherence under D churn; RD_START mid-stream and at the last accept are ignored.
    GN = '0; D = 32'h8877_6655;
    tick();
    GN = '1;
    do_read(-1, 0, 1'b1, 1'b1);
    GN = '1;
    tick();

    // Reset mid-stream at channel 2, then a fresh read from channel 0.
    GN = '0; D = 32'hDDCC_BBAA;
    tick();
    GN = '1; RD_START = 1'b1;
    tick();
    RD_START = 1'b0;
    tick();
    RD_READY = 1'b1;
    tick();
    tick();
    RD_READY = 1'b0;
    #1;
    chk("mid_ch2", 64'(RD_CH), 64'(2));
    RST = 1'b1;
    tick();
    chk("mid_rst_valid", 64'(RD_VALID), 64'(0));
    chk("mid_rst_done", 64'(RD_DONE), 64'(0));
    chk("mid_rst_q", 64'(Q), 64'(0));
    chk("mid_rst_ch", 64'(RD_CH), 64'(0));
    RST = 1'b0;
    GN = '0; D = 32'h0F1E_2D3C;
    tick();
    GN = '1;
    do_read(2, 1, 1'b0, 1'b0);

    // Gate-width check: 1-cycle open on ch2 flags, 2-cycle open on ch3 does not.
    RST = 1'b1; GN = '1;
    tick();
    RST = 1'b0;
    GN = 4'b1011;
    tick();
    GN = 4'b1111;
    tick();
`ifdef DLATN_BANK_WIDTH_CHECK_EN
    chk("wc_short", 64'(ERR), 64'(4'b0100));
`else
    chk("wc_short", 64'(ERR), 64'(4'b0000));
`endif
    GN = 4'b0111;
    tick();
    tick();
    GN = 4'b1111;
    tick();
    tick();
`ifdef DLATN_BANK_WIDTH_CHECK_EN
    chk("wc_long", 64'(ERR), 64'(4'b0100));
`else
    chk("wc_long", 64'(ERR), 64'(4'b0000));
`endif
    chk_q("wc_model");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
